log_update_sched: RTL

Sequencer for the log-domain weight-update pass of the functional-link adaptive filter. On each accepted error sample it walks all expansion-term taps. For each tap it reads the tap's log-magnitude term, adds it to the captured log-error (a log-domain multiply), and presents the product to the shared antilog LUT. It then issues the weight-memory write strobe aligned to the LUT latency. It sits between the log error stage and the antilog/weight-accumulate datapath and owns the order and timing of all tap updates.

---
 rtl/log_update_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/log_update_sched.sv
// rtl/log_update_sched.sv - log-domain weight-update sequencer for the functional-link adaptive filter
module log_update_sched #(
  parameter int NTAPS     = 8,
  parameter int TAP_W     = 3,
  parameter int LOG_WIDTH = 17,
  parameter int ALOG_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 err_valid,
  input  logic [LOG_WIDTH-1:0] log_error,
  input  logic                 log_error_sign,
  input  logic                 log_error_valid,
  output logic                 rd_en,
  output logic [TAP_W-1:0]     tap_addr,
  input  logic [LOG_WIDTH-1:0] x_log,
  input  logic                 x_sign,
  input  logic                 x_valid,
  output logic [LOG_WIDTH-1:0] prod_log,
  output logic                 prod_sign,
  output logic                 prod_valid,
  output logic                 w_we,
  output logic [TAP_W-1:0]     w_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err_drop
);

  // The drain covers the read-return cycle, the product register and the antilog latency.
  localparam int DRAIN_CYC = 2 + ALOG_LAT;
  localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [TAP_W-1:0]  LAST_TAP   = TAP_W'(NTAPS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);
  localparam logic [LOG_WIDTH-1:0] SAT_MAX = {1'b0, {(LOG_WIDTH-1){1'b1}}};
  localparam logic [LOG_WIDTH-1:0] SAT_MIN = {1'b1, {(LOG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [LOG_WIDTH-1:0] err_log_q;
  logic                 err_sign_q;
  logic [DCNT_W-1:0]    drain_cnt_q;
  logic                 rd_en_q;
  logic [TAP_W-1:0]     tap_addr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_drop_q;

  // Read-return alignment: which tap the returning x_log belongs to.
  logic                 rd_v_q;
  logic [TAP_W-1:0]     rd_tap_q;

  // Product stage.
  logic [LOG_WIDTH:0]   sum_d;
  logic [LOG_WIDTH-1:0] sat_d;
  logic                 prod_valid_q;
  logic [LOG_WIDTH-1:0] prod_log_q;
  logic                 prod_sign_q;
  logic [TAP_W-1:0]     prod_tap_q;

  // Antilog-latency delay line for the write strobe and its tap index.
  logic                 wv_q [ALOG_LAT];
  logic [TAP_W-1:0]     wa_q [ALOG_LAT];

  // Pass sequencer: captures the error, walks the taps, drains the pipe, pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      err_log_q   <= '0;
      err_sign_q  <= 1'b0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      tap_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_drop_q <= err_valid && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (err_valid) begin
            err_log_q  <= log_error;
            err_sign_q <= log_error_sign;
            busy_q     <= 1'b1;
            if (log_error_valid) begin
              state_q    <= S_ISSUE;
              rd_en_q    <= 1'b1;
              tap_addr_q <= '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (tap_addr_q == LAST_TAP) begin
            state_q     <= S_DRAIN;
            rd_en_q     <= 1'b0;
            tap_addr_q  <= '0;
            drain_cnt_q <= '0;
          end else begin
            tap_addr_q <= tap_addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Track the tap whose term is returning from the log buffer this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v_q   <= 1'b0;
      rd_tap_q <= '0;
    end else begin
      rd_v_q   <= rd_en_q;
      rd_tap_q <= tap_addr_q;
    end
  end

  // Log-domain multiply at one extra bit, clamped back into the signed word range.
  always_comb begin
    sum_d = {err_log_q[LOG_WIDTH-1], err_log_q} + {x_log[LOG_WIDTH-1], x_log};
    sat_d = sum_d[LOG_WIDTH-1:0];
    if (sum_d[LOG_WIDTH] != sum_d[LOG_WIDTH-1]) begin
      sat_d = sum_d[LOG_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Register the product; zero tap terms produce no product and a zeroed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid_q <= 1'b0;
      prod_log_q   <= '0;
      prod_sign_q  <= 1'b0;
      prod_tap_q   <= '0;
    end else begin
      prod_valid_q <= rd_v_q && x_valid;
      prod_tap_q   <= rd_tap_q;
      if (rd_v_q && x_valid) begin
        prod_log_q  <= sat_d;
        prod_sign_q <= err_sign_q ^ x_sign;
      end else begin
        prod_log_q  <= '0;
        prod_sign_q <= 1'b0;
      end
    end
  end

  // Delay the product strobe by the antilog latency so the write lands with the LUT result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ALOG_LAT; i++) begin
        wv_q[i] <= 1'b0;
        wa_q[i] <= '0;
      end
    end else begin
      wv_q[0] <= prod_valid_q;
      wa_q[0] <= prod_tap_q;
      for (int i = 1; i < ALOG_LAT; i++) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign tap_addr   = tap_addr_q;
  assign prod_log   = prod_log_q;
  assign prod_sign  = prod_sign_q;
  assign prod_valid = prod_valid_q;
  assign w_we       = wv_q[ALOG_LAT-1];
  assign w_addr     = wa_q[ALOG_LAT-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_drop   = err_drop_q;

endmodule
